mash_dsm_gen: RTL and testbench

Parametrised MASH 1-1-1 delta-sigma modulator with run-time selectable order (1/2/3), optional LSB dither and output saturation, generalising the fixed third-order, fixed-width core. It converts a held integer + fractional divide word into a per-cycle integer sequence whose mean equals int + frac/2^ACC_W. It drives the multi-modulus divider of the fractional-N loop and adds an enable/fill sequencer, a config handshake and a valid flag.

---
 rtl/mash_dsm_pkg.sv | 25 ++
 rtl/mash_acc_stage.sv | 31 +++
 rtl/mash_dsm_gen.sv | 189 ++++++++++++++++++
 tb/tb_mash_dsm_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mash_dsm_pkg.sv
// Shared types and constants for the MASH 1-1-1 delta-sigma generator.
package mash_dsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [1:0] ORD_BYP = 2'd0;
  localparam logic [1:0] ORD_1   = 2'd1;
  localparam logic [1:0] ORD_2   = 2'd2;
  localparam logic [1:0] ORD_3   = 2'd3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois toggle mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned FILL_CYCLES = 2;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// One MASH accumulator stage: registered accumulator, combinational next value and carry.
module mash_acc_stage #(
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [ACC_W-1:0] x,
  output logic [ACC_W-1:0] acc_nxt_c,
  output logic             carry_c
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum_c;

  assign sum_c     = {1'b0, acc} + {1'b0, x};
  assign acc_nxt_c = sum_c[ACC_W-1:0];
  assign carry_c   = sum_c[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt_c;
    end
  end

endmodule

// File: rtl/mash_dsm_gen.sv
// MASH 1-1-1 delta-sigma modulator with selectable order, LSB dither,
// output saturation and an enable/fill sequencer.
module mash_dsm_gen
  import mash_dsm_pkg::*;
#(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned INT_W = 4,
  parameter int unsigned OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [INT_W-1:0] cfg_int,
  input  logic [ACC_W-1:0] cfg_frac,
  input  logic [1:0]       cfg_order,
  input  logic             cfg_dither,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             sat
);

  localparam int unsigned SUM_W = INT_W + 3;
  localparam int unsigned CNT_W = 2;
  localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((2 ** OUT_W) - 1);

  state_e           state;
  logic [CNT_W-1:0] fill_cnt;

  logic [INT_W-1:0] int_q;
  logic [ACC_W-1:0] frac_q;
  logic [1:0]       order_q;
  logic             dither_q;
  logic [15:0]      lfsr;

  logic             c1_z1, c1_z2, c2_z1, c2_z2, c3_z1;
  logic signed [3:0] s_z1;
  logic [INT_W-1:0] int_z1, int_z2;

  logic             adv_c, clr_c;
  logic [ACC_W-1:0] x1_c, nxt1_c, nxt2_c, acc3_unused;
  logic             c1_c, c2_c, c3_c;

  logic signed [3:0] c1z2_s, c2z1_s, c2z2_s, c3_s, c3z1_s;
  logic signed [3:0] d1_c, s_c, d2_c, y_c;
  logic signed [SUM_W-1:0] sum_c;
  logic [OUT_W-1:0] out_nxt_c;
  logic             clamp_c;

  assign cfg_ready = 1'b1;
  assign adv_c     = en && (state != IDLE);
  assign clr_c     = !en;
  assign x1_c      = frac_q + ACC_W'(dither_q & lfsr[0]);

  // Three cascaded stages; each later stage integrates the previous stage's next residue
  mash_acc_stage #(.ACC_W(ACC_W)) u_stage1 (
    .clk(clk), .rst_n(rst_n), .en(adv_c), .clr(clr_c),
    .x(x1_c), .acc_nxt_c(nxt1_c), .carry_c(c1_c)
  );

  mash_acc_stage #(.ACC_W(ACC_W)) u_stage2 (
    .clk(clk), .rst_n(rst_n), .en(adv_c), .clr(clr_c),
    .x(nxt1_c), .acc_nxt_c(nxt2_c), .carry_c(c2_c)
  );

  mash_acc_stage #(.ACC_W(ACC_W)) u_stage3 (
    .clk(clk), .rst_n(rst_n), .en(adv_c), .clr(clr_c),
    .x(nxt2_c), .acc_nxt_c(acc3_unused), .carry_c(c3_c)
  );

  assign c1z2_s = signed'({3'b000, c1_z2});
  assign c2z1_s = signed'({3'b000, c2_z1});
  assign c2z2_s = signed'({3'b000, c2_z2});
  assign c3_s   = signed'({3'b000, c3_c});
  assign c3z1_s = signed'({3'b000, c3_z1});

  // Noise-cancellation network aligned so every order shares the same 2-cycle latency
  always_comb begin
    d1_c = c3_s - c3z1_s;
    s_c  = c2z1_s + d1_c;
    d2_c = s_c - s_z1;
    y_c  = '0;
    case (order_q)
      ORD_BYP: y_c = '0;
      ORD_1:   y_c = c1z2_s;
      ORD_2:   y_c = c1z2_s + c2z1_s - c2z2_s;
      ORD_3:   y_c = c1z2_s + d2_c;
    endcase
  end

  assign sum_c = SUM_W'(signed'({1'b0, int_z2})) + SUM_W'(y_c);

  always_comb begin
    out_nxt_c = OUT_W'(sum_c);
    clamp_c   = 1'b0;
    if (sum_c[SUM_W-1]) begin
      out_nxt_c = '0;
      clamp_c   = 1'b1;
    end else if (sum_c > OUT_MAX) begin
      out_nxt_c = '1;
      clamp_c   = 1'b1;
    end
  end

  // Sequencer, config capture, delay lines and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fill_cnt  <= '0;
      int_q     <= '0;
      frac_q    <= '0;
      order_q   <= '0;
      dither_q  <= 1'b0;
      lfsr      <= LFSR_SEED;
      c1_z1     <= 1'b0;
      c1_z2     <= 1'b0;
      c2_z1     <= 1'b0;
      c2_z2     <= 1'b0;
      c3_z1     <= 1'b0;
      s_z1      <= '0;
      int_z1    <= '0;
      int_z2    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
    end else begin
      if (cfg_valid) begin
        int_q  <= cfg_int;
        frac_q <= cfg_frac;
        if (state == IDLE) begin
          order_q  <= cfg_order;
          dither_q <= cfg_dither;
        end
      end

      if (!en) begin
        state     <= IDLE;
        fill_cnt  <= '0;
        c1_z1     <= 1'b0;
        c1_z2     <= 1'b0;
        c2_z1     <= 1'b0;
        c2_z2     <= 1'b0;
        c3_z1     <= 1'b0;
        s_z1      <= '0;
        int_z1    <= '0;
        int_z2    <= '0;
        out       <= '0;
        out_valid <= 1'b0;
        sat       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state    <= FILL;
            fill_cnt <= '0;
          end
          FILL: begin
            fill_cnt  <= fill_cnt + CNT_W'(1);
            out_valid <= 1'b0;
            if (fill_cnt == CNT_W'(FILL_CYCLES - 1)) begin
              state <= RUN;
            end
          end
          RUN: begin
            out_valid <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase

        if (state != IDLE) begin
          c1_z1  <= c1_c;
          c1_z2  <= c1_z1;
          c2_z1  <= c2_c;
          c2_z2  <= c2_z1;
          c3_z1  <= c3_c;
          s_z1   <= s_c;
          int_z1 <= int_q;
          int_z2 <= int_z1;
          out    <= out_nxt_c;
          sat    <= clamp_c;
          lfsr   <= lfsr_step(lfsr);
        end
      end
    end
  end

endmodule

// File: tb/tb_mash_dsm_gen.sv
// Self-checking bench for mash_dsm_gen against a cycle-level arithmetic MASH model.
module tb_mash_dsm_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_int = '0;
  logic [15:0] cfg_frac = '0;
  logic [1:0]  cfg_order = '0;
  logic        cfg_dither = 1'b0;
  logic [3:0]  out;
  logic        out_valid;
  logic        sat;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mash_dsm_gen #(.ACC_W(16), .INT_W(4), .OUT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_int(cfg_int), .cfg_frac(cfg_frac), .cfg_order(cfg_order), .cfg_dither(cfg_dither),
    .out(out), .out_valid(out_valid), .sat(sat)
  );

  // Reference model state: config, accumulators as integers, carry/int histories
  int          m_run, m_cnt, m_int, m_frac, m_order;
  bit          m_dither;
  logic [15:0] m_lfsr;
  int          m_acc1, m_acc2, m_acc3;
  int          c1p1, c1p2, c2p1, c2p2, c3p1, c3p2, ih1, ih2;
  int          m_sum;
  logic [3:0]  exp_out;
  logic        exp_valid, exp_sat;
  int          exp_sat_cnt, dut_sat_cnt;

  task automatic model_clear();
    m_run = 0; m_cnt = 0;
    m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
    c1p1 = 0; c1p2 = 0; c2p1 = 0; c2p2 = 0; c3p1 = 0; c3p2 = 0; ih1 = 0; ih2 = 0;
    m_sum = 0; exp_out = '0; exp_valid = 1'b0; exp_sat = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_int = 0; m_frac = 0; m_order = 0; m_dither = 1'b0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_edge();
    bit was_idle;
    was_idle = (m_run == 0);
    if (!en) begin
      model_clear();
    end else if (was_idle) begin
      m_run = 1; m_cnt = 0;
    end else begin : adv
      int x1, t, c1, c2, c3, y;
      bit lsb;
      x1 = (m_frac + ((m_dither && m_lfsr[0]) ? 1 : 0)) % 65536;
      t = m_acc1 + x1;   c1 = t / 65536; m_acc1 = t % 65536;
      t = m_acc2 + m_acc1; c2 = t / 65536; m_acc2 = t % 65536;
      t = m_acc3 + m_acc2; c3 = t / 65536; m_acc3 = t % 65536;
      case (m_order)
        1: y = c1p2;
        2: y = c1p2 + (c2p1 - c2p2);
        3: y = c1p2 + (c2p1 - c2p2) + (c3 - 2 * c3p1 + c3p2);
        default: y = 0;
      endcase
      m_sum     = ih2 + y;
      exp_sat   = (m_sum < 0) || (m_sum > 15);
      exp_out   = 4'((m_sum < 0) ? 0 : ((m_sum > 15) ? 15 : m_sum));
      exp_valid = (m_cnt >= 2);
      if (exp_valid && m_sum > 15) exp_sat_cnt++;
      c1p2 = c1p1; c1p1 = c1;
      c2p2 = c2p1; c2p1 = c2;
      c3p2 = c3p1; c3p1 = c3;
      ih2 = ih1; ih1 = m_int;
      m_cnt++;
      lsb = m_lfsr[0];
      m_lfsr = m_lfsr >> 1;
      if (lsb) m_lfsr = m_lfsr ^ 16'hB400;
    end
    if (cfg_valid) begin
      m_int  = int'(cfg_int);
      m_frac = int'(cfg_frac);
      if (was_idle) begin
        m_order  = int'(cfg_order);
        m_dither = cfg_dither;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    compared++;
    assert (got === expv) else begin
      mismatched++;
      $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, expv, $time);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("out", 32'(out), 32'(exp_out));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("sat", 32'(sat), 32'(exp_sat));
    if (out_valid && sat) dut_sat_cnt++;
  endtask

  task automatic set_cfg(input int i, input int f, input int o, input bit d);
    cfg_int = 4'(i); cfg_frac = 16'(f); cfg_order = 2'(o); cfg_dither = d;
  endtask

  initial begin : main
    int vals[$];
    int sum, nvalid, vmin, vmax, guard;
    bit sat_seen;

    model_reset();
    #12;
    chk("rst_out", 32'(out), 32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_sat", 32'(sat), 32'(0));
    chk("cfg_ready", 32'(cfg_ready), 32'(1));
    rst_n = 1'b1;
    tick();

    // 1: integer-only, order 3
    set_cfg(5, 0, 3, 1'b0); cfg_valid = 1'b1; en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick(); tick();
    chk("t1_valid_e2", 32'(out_valid), 32'(0));
    tick();
    chk("t1_valid_e3", 32'(out_valid), 32'(1));
    chk("t1_out_e3", 32'(out), 32'(5));
    sat_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sat) sat_seen = 1'b1;
      chk("t1_out5", 32'(out), 32'(5));
    end
    chk("t1_no_sat", 32'(sat_seen), 32'(0));

    // 2: order 1 half-step alternation
    en = 1'b0; tick();
    chk("t2_idle_out", 32'(out), 32'(0));
    set_cfg(5, 16'h8000, 1, 1'b0); cfg_valid = 1'b1; en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    vals.delete();
    guard = 0;
    while (vals.size() < 8 && guard < 20) begin
      tick(); guard++;
      if (out_valid) vals.push_back(int'(out));
    end
    chk("t2_got8", 32'(vals.size()), 32'(8));
    for (int i = 0; i < vals.size(); i++) chk("t2_alt", 32'(vals[i]), 32'((i % 2 == 0) ? 5 : 6));

    // 3: long-run mean for order 3
    en = 1'b0; tick();
    set_cfg(7, 16'h4000, 3, 1'b0); cfg_valid = 1'b1; en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    sum = 0; nvalid = 0; vmin = 99; vmax = -1; guard = 0;
    while (nvalid < 4096 && guard < 4200) begin
      tick(); guard++;
      if (out_valid) begin
        sum += int'(out); nvalid++;
        if (int'(out) < vmin) vmin = int'(out);
        if (int'(out) > vmax) vmax = int'(out);
      end
    end
    chk("t3_count", 32'(nvalid), 32'(4096));
    chk("t3_sum_tol", 32'((sum >= 29692) && (sum <= 29700)), 32'(1));
    chk("t3_min_ge4", 32'(vmin >= 4), 32'(1));
    chk("t3_max_le11", 32'(vmax <= 11), 32'(1));

    // 4: saturation at the top of the range
    en = 1'b0; tick();
    set_cfg(15, 16'hC000, 3, 1'b0); cfg_valid = 1'b1; en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    exp_sat_cnt = 0; dut_sat_cnt = 0;
    for (int i = 0; i < 200; i++) tick();
    chk("t4_sat_count", 32'(dut_sat_cnt), 32'(exp_sat_cnt));
    chk("t4_sat_nonzero", 32'(exp_sat_cnt > 0), 32'(1));

    // 5: order change ignored in RUN, accepted in IDLE
    en = 1'b0; tick();
    set_cfg(6, 16'h3A51, 3, 1'b0); cfg_valid = 1'b1; en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    cfg_order = 2'd2; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    en = 1'b0; tick();
    chk("t5_idle_out", 32'(out), 32'(0));
    chk("t5_idle_valid", 32'(out_valid), 32'(0));
    set_cfg(6, 16'h3A51, 2, 1'b0); cfg_valid = 1'b1; en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    // 6: asynchronous reset mid-run
    en = 1'b0; tick();
    set_cfg(9, 16'h1234, 3, 1'b0); cfg_valid = 1'b1; en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    #3; rst_n = 1'b0; #1;
    chk("t6_rst_out", 32'(out), 32'(0));
    chk("t6_rst_valid", 32'(out_valid), 32'(0));
    chk("t6_rst_sat", 32'(sat), 32'(0));
    model_reset();
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_hold_valid", 32'(out_valid), 32'(0));
    end
    set_cfg(9, 16'h1234, 3, 1'b1); cfg_valid = 1'b1; en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 30; i++) tick();

    // Randomized segments with mid-run config updates and dither
    for (int seg = 0; seg < 8; seg++) begin
      en = 1'b0; tick();
      set_cfg(int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      cfg_valid = 1'b1; en = 1'b1;
      tick();
      cfg_valid = 1'b0;
      for (int i = 0; i < int'($urandom_range(30, 120)); i++) begin
        if ($urandom_range(0, 15) == 0) begin
          set_cfg(int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
          cfg_valid = 1'b1;
        end else begin
          cfg_valid = 1'b0;
        end
        tick();
      end
      cfg_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
